// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet transmit arbiter.
package eth_tx_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, PASS, GAP} tx_arb_state_t;

  localparam logic REQ_VIDEO  = 1'b0;
  localparam logic REQ_STATUS = 1'b1;

  localparam int unsigned IPG_CYCLES_DEFAULT = 48;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// Combinational 2-way round-robin pick: on a tie the requester that is not
// the current owner wins; a lone requester always wins.
module tx_rr_pick (
  input  logic [1:0] req,
  input  logic       owner,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~owner : req[1];
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Two-source dibit transmit arbiter with start timeout, length abort and IPG.
// Optional statistics counters are built when ETH_TX_ARB_STATS_EN is defined.
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int unsigned IPG_CYCLES     = IPG_CYCLES_DEFAULT,
  parameter int unsigned START_TIMEOUT  = 16,
  parameter int unsigned MAX_PKT_CYCLES = 4096
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic [1:0]       req,
  output logic [1:0]       ready,
  input  logic [1:0]       src_axiov,
  input  logic [1:0][1:0]  src_axiod,
  output logic             axiov,
  output logic [1:0]       axiod,
  output logic             busy,
  output logic             owner,
  output logic [1:0][15:0] pkt_count,
  output logic [15:0]      abort_count
);

  localparam int unsigned WW = $clog2(START_TIMEOUT + 1);
  localparam int unsigned LW = $clog2(MAX_PKT_CYCLES + 1);
  localparam int unsigned GW = $clog2(IPG_CYCLES + 1);

  localparam logic [WW-1:0] WAIT_LAST = WW'(START_TIMEOUT - 1);
  localparam logic [LW-1:0] LEN_LAST  = LW'(MAX_PKT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(IPG_CYCLES - 1);

  tx_arb_state_t state;
  logic [WW-1:0] wait_cnt;
  logic [LW-1:0] len_cnt;
  logic [GW-1:0] gap_cnt;

  logic       pick_winner;
  logic       pick_valid;
  logic       own_v;
  logic [1:0] own_d;
  logic       start_to;
  logic       len_ovr;

  tx_rr_pick u_pick (
    .req    (req),
    .owner  (owner),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_comb begin
    own_v    = src_axiov[owner];
    own_d    = src_axiod[owner];
    start_to = (state == WAIT) && !own_v && (wait_cnt == WAIT_LAST);
    // The dibit accepted this cycle would be the MAX_PKT_CYCLES-th one.
    len_ovr  = (state == PASS) && own_v && (len_cnt == LEN_LAST);
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= '0;
      axiov    <= 1'b0;
      axiod    <= '0;
      busy     <= 1'b0;
      owner    <= REQ_STATUS;
      wait_cnt <= '0;
      len_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      ready <= '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            ready    <= req_onehot(pick_winner);
            owner    <= pick_winner;
            wait_cnt <= '0;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // The first dibit is forwarded on the transition so nothing is lost.
          if (own_v) begin
            axiov   <= 1'b1;
            axiod   <= own_d;
            len_cnt <= LW'(1);
            state   <= PASS;
          end else if (start_to) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        PASS: begin
          axiov <= own_v;
          axiod <= own_d;
          if (!own_v || len_ovr) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            len_cnt <= len_cnt + LW'(1);
          end
        end
        GAP: begin
          axiov <= 1'b0;
          axiod <= '0;
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  logic pkt_end;
  assign pkt_end = (state == PASS) && !own_v;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      pkt_count   <= '0;
      abort_count <= '0;
    end else begin
      if (pkt_end)
        pkt_count[owner] <= pkt_count[owner] + 16'd1;
      if (start_to || len_ovr)
        abort_count <= abort_count + 16'd1;
    end
  end
`else
  assign pkt_count   = '0;
  assign abort_count = '0;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed self-checking bench for eth_tx_arbiter; counter expectations follow
// whether ETH_TX_ARB_STATS_EN is defined for the build.
module tb_eth_tx_arbiter;

  localparam int IPG  = 48;
  localparam int STO  = 16;
  localparam int MAXP = 4096;
`ifdef ETH_TX_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic             clk_50mhz = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       ready;
  logic [1:0]       src_axiov;
  logic [1:0][1:0]  src_axiod;
  logic             axiov;
  logic [1:0]       axiod;
  logic             busy;
  logic             owner;
  logic [1:0][15:0] pkt_count;
  logic [15:0]      abort_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  eth_tx_arbiter #(
    .IPG_CYCLES     (IPG),
    .START_TIMEOUT  (STO),
    .MAX_PKT_CYCLES (MAXP)
  ) dut (
    .clk_50mhz   (clk_50mhz),
    .rst         (rst),
    .req         (req),
    .ready       (ready),
    .src_axiov   (src_axiov),
    .src_axiod   (src_axiod),
    .axiov       (axiov),
    .axiod       (axiod),
    .busy        (busy),
    .owner       (owner),
    .pkt_count   (pkt_count),
    .abort_count (abort_count)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step;
    @(posedge clk_50mhz);
    #1;
    cyc++;
  endtask

  function automatic logic [1:0] pat(input int k);
    return 2'((k ^ (k >> 2) ^ (k >> 5)) & 3);
  endfunction

  task automatic do_reset;
    rst = 1'b1; req = '0; src_axiov = '0; src_axiod = '0;
    step; step;
    rst = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin step; n++; end
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", ready); end
    total++; if (axiov !== 1'b0) begin bad++; $display("FAIL reset_axiov got=%b want=0", axiov); end
    total++; if (axiod !== 2'b00) begin bad++; $display("FAIL reset_axiod got=%b want=00", axiod); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (owner !== 1'b1) begin bad++; $display("FAIL reset_owner got=%b want=1", owner); end
    total++; if (pkt_count !== 32'h0) begin bad++; $display("FAIL reset_pkt got=%h want=0", pkt_count); end
    total++; if (abort_count !== 16'h0) begin bad++; $display("FAIL reset_abort got=%0d want=0", abort_count); end
  endtask

  task automatic test_single;
    int errs, n;
    do_reset;
    src_axiov[1] = 1'b1; src_axiod[1] = 2'b11;  // non-owner noise
    req = 2'b01;
    step;
    total++; if (ready !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", ready); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL single_owner got=%b want=0", owner); end
    req = '0;
    step;
    errs = 0;
    if (ready !== 2'b00 || axiov !== 1'b0) errs++;
    for (int k = 0; k < 1928; k++) begin
      src_axiov[0] = 1'b1; src_axiod[0] = pat(k);
      step;
      if (axiov !== 1'b1 || axiod !== pat(k) || ready !== 2'b00) begin
        if (errs == 0) $display("FAIL single_data k=%0d got=%b/%b want=1/%b", k, axiov, axiod, pat(k));
        errs++;
      end
    end
    src_axiov[0] = 1'b0; src_axiod[0] = 2'b00;
    step;
    total++; if (errs !== 0) begin bad++; $display("FAIL single_fwd got=%0d errors want=0", errs); end
    total++; if (axiov !== 1'b0) begin bad++; $display("FAIL single_end got=%b want=0", axiov); end
    total++; if (pkt_count[0] !== 16'(STATS)) begin bad++; $display("FAIL single_pkt0 got=%0d want=%0d", pkt_count[0], STATS); end
    total++; if (pkt_count[1] !== 16'd0) begin bad++; $display("FAIL single_pkt1 got=%0d want=0", pkt_count[1]); end
    req = 2'b01;
    n = 0; errs = 0;
    while (ready !== 2'b01 && n < 200) begin
      if (axiov !== 1'b0) errs++;
      step; n++;
    end
    total++; if (n !== IPG + 1) begin bad++; $display("FAIL single_ipg got=%0d want=%0d", n, IPG + 1); end
    total++; if (errs !== 0) begin bad++; $display("FAIL single_gap_idle got=%0d want=0", errs); end
    src_axiov = '0; src_axiod = '0; req = '0;
  endtask

  task automatic test_contention;
    int n, errs, first, last, exp_o;
    do_reset;
    req = 2'b11;
    last = 0;
    for (int p = 0; p < 4; p++) begin
      exp_o = p % 2;
      n = 0;
      while (ready === 2'b00 && n < 200) begin step; n++; end
      total++; if (ready !== (exp_o != 0 ? 2'b10 : 2'b01)) begin bad++; $display("FAIL cont_grant p=%0d got=%b want_owner=%0d", p, ready, exp_o); end
      total++; if (owner !== 1'(exp_o)) begin bad++; $display("FAIL cont_owner p=%0d got=%b want=%0d", p, owner, exp_o); end
      step;
      errs = 0; first = 0;
      for (int k = 0; k < 100; k++) begin
        src_axiov[exp_o] = 1'b1; src_axiod[exp_o] = pat(k + p);
        step;
        if (k == 0) first = cyc;
        if (axiov !== 1'b1 || axiod !== pat(k + p)) errs++;
      end
      src_axiov = '0; src_axiod = '0;
      step;
      if (axiov !== 1'b0) errs++;
      total++; if (errs !== 0) begin bad++; $display("FAIL cont_data p=%0d got=%0d errors want=0", p, errs); end
      if (p > 0) begin
        total++; if (first - last - 1 !== IPG + 3) begin bad++; $display("FAIL cont_spacing p=%0d got=%0d want=%0d", p, first - last - 1, IPG + 3); end
      end
      last = first + 99;
    end
    total++; if (pkt_count[0] !== 16'(2 * STATS) || pkt_count[1] !== 16'(2 * STATS)) begin bad++; $display("FAIL cont_pkt got=%0d,%0d want=%0d", pkt_count[0], pkt_count[1], 2 * STATS); end
    total++; if (abort_count !== 16'd0) begin bad++; $display("FAIL cont_abort got=%0d want=0", abort_count); end
    req = '0;
  endtask

  task automatic test_timeout;
    int n, errs;
    do_reset;
    req = 2'b10;
    step;
    total++; if (ready !== 2'b10 || owner !== 1'b1) begin bad++; $display("FAIL to_grant got=%b/%b want=10/1", ready, owner); end
    req = '0;
    src_axiov[0] = 1'b1; src_axiod[0] = 2'b10;  // non-owner must not start the packet
    errs = 0;
    for (int i = 1; i < STO; i++) begin step; if (axiov !== 1'b0) errs++; end
    total++; if (abort_count !== 16'd0 || busy !== 1'b1) begin bad++; $display("FAIL to_early got=%0d/%b want=0/1", abort_count, busy); end
    step;
    total++; if (abort_count !== 16'(STATS)) begin bad++; $display("FAIL to_abort got=%0d want=%0d", abort_count, STATS); end
    n = 0;
    while (busy === 1'b1 && n < 200) begin if (axiov !== 1'b0) errs++; step; n++; end
    total++; if (n !== IPG) begin bad++; $display("FAIL to_gap got=%0d want=%0d", n, IPG); end
    total++; if (errs !== 0) begin bad++; $display("FAIL to_novalid got=%0d want=0", errs); end
    src_axiov = '0; src_axiod = '0;
  endtask

  task automatic test_overrun;
    int nv, errs, n;
    do_reset;
    req = 2'b01; step; req = '0; step;
    nv = 0; errs = 0;
    for (int k = 0; k < 5000; k++) begin
      src_axiov[0] = 1'b1; src_axiod[0] = pat(k);
      step;
      if (axiov === 1'b1) nv++;
      if (k < MAXP) begin
        if (axiov !== 1'b1 || axiod !== pat(k)) errs++;
      end else if (axiov !== 1'b0 || axiod !== 2'b00) errs++;
    end
    src_axiov = '0; src_axiod = '0;
    step;
    total++; if (nv !== MAXP) begin bad++; $display("FAIL ovr_len got=%0d want=%0d", nv, MAXP); end
    total++; if (errs !== 0) begin bad++; $display("FAIL ovr_data got=%0d errors want=0", errs); end
    total++; if (abort_count !== 16'(STATS)) begin bad++; $display("FAIL ovr_abort got=%0d want=%0d", abort_count, STATS); end
    total++; if (pkt_count[0] !== 16'd0) begin bad++; $display("FAIL ovr_pkt got=%0d want=0", pkt_count[0]); end
    wait_idle(n);
    total++; if (n >= 200) begin bad++; $display("FAIL ovr_idle got=%0d want<200", n); end
    req = 2'b01; step; req = '0; step;
    errs = 0;
    for (int k = 0; k < MAXP - 1; k++) begin
      src_axiov[0] = 1'b1; src_axiod[0] = pat(k);
      step;
      if (axiov !== 1'b1 || axiod !== pat(k)) errs++;
    end
    src_axiov = '0; src_axiod = '0;
    step;
    if (axiov !== 1'b0) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL max1_data got=%0d errors want=0", errs); end
    total++; if (pkt_count[0] !== 16'(STATS) || abort_count !== 16'(STATS)) begin bad++; $display("FAIL max1_counts got=%0d/%0d want=%0d/%0d", pkt_count[0], abort_count, STATS, STATS); end
  endtask

  task automatic test_reset_mid_pass;
    int n;
    do_reset;
    req = 2'b10; step; req = '0; step;
    for (int k = 0; k < 10; k++) begin src_axiov[1] = 1'b1; src_axiod[1] = pat(k); step; end
    src_axiov = '0; src_axiod = '0;
    step;
    wait_idle(n);
    total++; if (n >= 200 || pkt_count[1] !== 16'(STATS)) begin bad++; $display("FAIL rmp_pre got=%0d/%0d want<200/%0d", n, pkt_count[1], STATS); end
    req = 2'b11; step;
    total++; if (ready !== 2'b01) begin bad++; $display("FAIL rmp_tie got=%b want=01", ready); end
    req = '0; step;
    for (int k = 0; k < 499; k++) begin src_axiov[0] = 1'b1; src_axiod[0] = pat(k); step; end
    total++; if (axiov !== 1'b1) begin bad++; $display("FAIL rmp_inpkt got=%b want=1", axiov); end
    src_axiod[0] = 2'b11; rst = 1'b1;
    step;
    total++; if (axiov !== 1'b0 || axiod !== 2'b00) begin bad++; $display("FAIL rmp_out got=%b/%b want=0/00", axiov, axiod); end
    total++; if (busy !== 1'b0 || owner !== 1'b1 || ready !== 2'b00) begin bad++; $display("FAIL rmp_state got=%b/%b/%b want=0/1/00", busy, owner, ready); end
    total++; if (pkt_count !== 32'h0 || abort_count !== 16'h0) begin bad++; $display("FAIL rmp_counts got=%h/%0d want=0/0", pkt_count, abort_count); end
    rst = 1'b0; src_axiov = '0; src_axiod = '0; req = 2'b11;
    step;
    total++; if (ready !== 2'b01 || owner !== 1'b0) begin bad++; $display("FAIL rmp_regrant got=%b/%b want=01/0", ready, owner); end
    req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; src_axiov = '0; src_axiod = '0;
    test_reset;
    test_single;
    test_contention;
    test_timeout;
    test_overrun;
    test_reset_mid_pass;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
